// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-master arbiter sharing one stalling memory between an
//                instruction-fetch port and a data (load/store) port.
//                Data requests normally win. After MAX_DSTREAK consecutive
//                data grants made while a fetch was waiting, the fetch wins
//                the next arbitration. A grant that waits TIMEOUT cycles
//                without mem_ready ends with a zero response and sets the
//                sticky err flag.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1   single clock, rising edge
//    rst            in   1   asynchronous reset, active low
//    imem_req       in   1   fetch request (held until imem_ready)
//    imem_addr      in  16   fetch address
//    imem_data_out  out 32   fetch data, valid with imem_ready
//    imem_ready     out  1   one-cycle fetch completion pulse
//    dmem_req       in   1   data request (held until dmem_ready)
//    dmem_wr        in   1   1 = store, 0 = load
//    dmem_addr      in  16   data address
//    dmem_data_in   in  32   store data
//    dmem_data_out  out 32   load data, valid with dmem_ready
//    dmem_ready     out  1   one-cycle data completion pulse
//    mem_enable     out  1   memory access in progress
//    mem_wr         out  1   memory write strobe
//    mem_addr       out 16   memory address
//    mem_data_in    out 32   memory write data
//    mem_data_out   in  32   memory read data
//    mem_ready      in   1   memory completion
//    err            out  1   sticky memory-timeout flag
// ============================================================================
module mem_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_req,
    input  logic [15:0] imem_addr,
    output logic [31:0] imem_data_out,
    output logic        imem_ready,
    input  logic        dmem_req,
    input  logic        dmem_wr,
    input  logic [15:0] dmem_addr,
    input  logic [31:0] dmem_data_in,
    output logic [31:0] dmem_data_out,
    output logic        dmem_ready,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    input  logic        mem_ready,
    output logic        err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Counter widths are sized so the terminal value itself is representable.
    localparam int c_SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
    localparam int c_WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [c_SW-1:0] c_MAX_STREAK = c_SW'(MAX_DSTREAK);
    localparam logic [c_WW-1:0] c_TIMEOUT    = c_WW'(TIMEOUT);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_IGNT = 2'd1;
    localparam logic [1:0] c_S_DGNT = 2'd2;
    localparam logic [1:0] c_S_RESP = 2'd3;

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [c_SW-1:0] r_streak;
    logic [c_WW-1:0] r_wait;
    logic            r_err;
    logic            r_imem_ready;
    logic [31:0]     r_imem_data;
    logic            r_dmem_ready;
    logic [31:0]     r_dmem_data;
    logic            r_mem_en;
    logic            r_mem_wr;
    logic [15:0]     r_mem_addr;
    logic [31:0]     r_mem_din;

    // ------------------------------------------------------------------------
    // Arbitration decode
    // ------------------------------------------------------------------------
    logic            w_pick_d;
    logic            w_pick_i;
    logic [c_SW-1:0] w_streak_nxt;
    logic [c_WW-1:0] w_wait_inc;
    logic            w_timeout;
    logic            w_in_grant;
    logic            w_is_fetch;

    // The data port wins unless a fetch is waiting and the data port has
    // already used up its run of back-to-back grants.
    assign w_pick_d = dmem_req && (!imem_req || (r_streak < c_MAX_STREAK));
    assign w_pick_i = !w_pick_d && imem_req;

    // Streak counts only data grants that starved a waiting fetch; a data
    // grant with no competing fetch starts the count over.
    assign w_streak_nxt = !imem_req                   ? '0       :
                          (r_streak == c_MAX_STREAK)  ? r_streak :
                                                        r_streak + c_SW'(1);

    // Timeout fires on the grant cycle whose stall would make the wait
    // count reach TIMEOUT, so exactly TIMEOUT stalled grant cycles elapse.
    assign w_wait_inc = r_wait + c_WW'(1);
    assign w_timeout  = (w_wait_inc == c_TIMEOUT);

    assign w_in_grant = (r_state == c_S_IGNT) || (r_state == c_S_DGNT);
    assign w_is_fetch = (r_state == c_S_IGNT);

    // ------------------------------------------------------------------------
    // Control FSM, arbitration counters and memory-side request registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_S_IDLE;
            r_streak   <= '0;
            r_wait     <= '0;
            r_err      <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_pick_d) begin
                        r_state    <= c_S_DGNT;
                        r_streak   <= w_streak_nxt;
                        r_wait     <= '0;
                        r_mem_en   <= 1'b1;
                        r_mem_wr   <= dmem_wr;
                        r_mem_addr <= dmem_addr;
                        r_mem_din  <= dmem_data_in;
                    end else if (w_pick_i) begin
                        // A fetch is always a read; no store data rides along.
                        r_state    <= c_S_IGNT;
                        r_streak   <= '0;
                        r_wait     <= '0;
                        r_mem_en   <= 1'b1;
                        r_mem_wr   <= 1'b0;
                        r_mem_addr <= imem_addr;
                        r_mem_din  <= '0;
                    end
                end

                c_S_IGNT, c_S_DGNT: begin
                    if (mem_ready) begin
                        r_state  <= c_S_RESP;
                        r_mem_en <= 1'b0;
                        r_mem_wr <= 1'b0;
                    end else if (w_timeout) begin
                        r_state  <= c_S_RESP;
                        r_err    <= 1'b1;
                        r_mem_en <= 1'b0;
                        r_mem_wr <= 1'b0;
                    end else begin
                        r_wait <= w_wait_inc;
                    end
                end

                c_S_RESP: begin
                    r_state <= c_S_IDLE;
                end

                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Requester-side response registers
    // ------------------------------------------------------------------------
    // Ready pulses are raised on the grant->RESP edge and cleared on the
    // RESP->IDLE edge, so each lasts exactly the RESP cycle. Only one grant
    // state is ever active, so the two pulses can never coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_imem_ready <= 1'b0;
            r_imem_data  <= '0;
            r_dmem_ready <= 1'b0;
            r_dmem_data  <= '0;
        end else begin
            r_imem_ready <= 1'b0;
            r_dmem_ready <= 1'b0;
            if (w_in_grant && (mem_ready || w_timeout)) begin
                if (w_is_fetch) begin
                    r_imem_ready <= 1'b1;
                    r_imem_data  <= mem_ready ? mem_data_out : 32'h0;
                end else begin
                    r_dmem_ready <= 1'b1;
                    // A completed store leaves the load-data register alone;
                    // a timed-out access always returns zero.
                    if (!mem_ready) begin
                        r_dmem_data <= 32'h0;
                    end else if (!r_mem_wr) begin
                        r_dmem_data <= mem_data_out;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_data_out = r_imem_data;
    assign imem_ready    = r_imem_ready;
    assign dmem_data_out = r_dmem_data;
    assign dmem_ready    = r_dmem_ready;
    assign mem_enable    = r_mem_en;
    assign mem_wr        = r_mem_wr;
    assign mem_addr      = r_mem_addr;
    assign mem_data_in   = r_mem_din;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A stalling memory with
//                programmable wait states serves the DUT; a transaction-level
//                reference predicts every output each cycle, and directed
//                checks pin key cycles with literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_MAXD = 4;
    localparam int c_TO   = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req = 1'b0;
    logic [15:0] imem_addr = '0;
    logic [31:0] imem_data_out;
    logic        imem_ready;
    logic        dmem_req = 1'b0;
    logic        dmem_wr = 1'b0;
    logic [15:0] dmem_addr = '0;
    logic [31:0] dmem_data_in = '0;
    logic [31:0] dmem_data_out;
    logic        dmem_ready;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_ready;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(.MAX_DSTREAK(c_MAXD), .TIMEOUT(c_TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_data_out (imem_data_out),
        .imem_ready    (imem_ready),
        .dmem_req      (dmem_req),
        .dmem_wr       (dmem_wr),
        .dmem_addr     (dmem_addr),
        .dmem_data_in  (dmem_data_in),
        .dmem_data_out (dmem_data_out),
        .dmem_ready    (dmem_ready),
        .mem_enable    (mem_enable),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_data_in   (mem_data_in),
        .mem_data_out  (mem_data_out),
        .mem_ready     (mem_ready),
        .err           (err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Stalling memory: ready after wait_cfg extra cycles, or never when
    // hold_low is set. Unwritten words read as C0DE0000 | addr[7:0].
    // ------------------------------------------------------------------------
    int          wait_cfg = 0;
    bit          hold_low = 1'b0;
    int          env_cnt = 0;
    logic [31:0] env_mem [0:255];
    logic        env_vld [0:255] = '{default: 1'b0};

    assign mem_ready    = mem_enable && !hold_low && (env_cnt == wait_cfg);
    assign mem_data_out = env_vld[mem_addr[7:0]] ? env_mem[mem_addr[7:0]]
                                                 : (32'hC0DE0000 | {24'h0, mem_addr[7:0]});

    always @(posedge clk) begin
        env_cnt <= (mem_enable && !mem_ready) ? env_cnt + 1 : 0;
        if (mem_enable && mem_ready && mem_wr) begin
            env_mem[mem_addr[7:0]] <= mem_data_in;
            env_vld[mem_addr[7:0]] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Reference model: a transaction is a winner chosen by the streak rule,
    // a known number of grant cycles (memory waits + 1, or TIMEOUT when the
    // memory never answers), then one response cycle.
    // ------------------------------------------------------------------------
    logic [31:0] model_mem [0:255];
    logic        model_vld [0:255] = '{default: 1'b0};

    int          m_busy = 0;       // 0 free, 1 memory access, 2 responding
    int          m_left = 0;       // grant cycles still to go
    int          m_streak = 0;
    bit          m_fetch = 1'b0;
    bit          m_to = 1'b0;
    logic        e_imem_ready = 1'b0, e_dmem_ready = 1'b0, e_err = 1'b0;
    logic        e_mem_en = 1'b0, e_mem_wr = 1'b0;
    logic [15:0] e_mem_addr = '0;
    logic [31:0] e_mem_din = '0, e_imem_data = '0, e_dmem_data = '0;

    function automatic logic [31:0] model_read(input logic [15:0] a);
        return model_vld[a[7:0]] ? model_mem[a[7:0]] : (32'hC0DE0000 | {24'h0, a[7:0]});
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0; m_left = 0; m_streak = 0;
            e_imem_ready = 0; e_dmem_ready = 0; e_err = 0;
            e_mem_en = 0; e_mem_wr = 0; e_mem_addr = '0; e_mem_din = '0;
            e_imem_data = '0; e_dmem_data = '0;
        end else if (m_busy == 2) begin
            e_imem_ready = 0;
            e_dmem_ready = 0;
            m_busy = 0;
        end else if (m_busy == 1) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                e_mem_en = 0;
                if (m_to) begin
                    e_err = 1;
                    if (m_fetch) e_imem_data = 32'h0; else e_dmem_data = 32'h0;
                end else if (m_fetch) begin
                    e_imem_data = model_read(e_mem_addr);
                end else if (e_mem_wr) begin
                    model_mem[e_mem_addr[7:0]] = e_mem_din;
                    model_vld[e_mem_addr[7:0]] = 1'b1;
                end else begin
                    e_dmem_data = model_read(e_mem_addr);
                end
                e_mem_wr = 0;
                if (m_fetch) e_imem_ready = 1; else e_dmem_ready = 1;
                m_busy = 2;
            end
        end else if (dmem_req || imem_req) begin
            m_fetch = !(dmem_req && (!imem_req || m_streak < c_MAXD));
            if (m_fetch) begin
                m_streak = 0;
                e_mem_wr = 0; e_mem_addr = imem_addr; e_mem_din = 32'h0;
            end else begin
                m_streak = imem_req ? ((m_streak < c_MAXD) ? m_streak + 1 : c_MAXD) : 0;
                e_mem_wr = dmem_wr; e_mem_addr = dmem_addr; e_mem_din = dmem_data_in;
            end
            e_mem_en = 1;
            m_to   = hold_low;
            m_left = hold_low ? c_TO : wait_cfg + 1;
            m_busy = 1;
        end
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("imem_ready",    {31'h0, imem_ready},  {31'h0, e_imem_ready});
        chk("dmem_ready",    {31'h0, dmem_ready},  {31'h0, e_dmem_ready});
        chk("imem_data_out", imem_data_out,        e_imem_data);
        chk("dmem_data_out", dmem_data_out,        e_dmem_data);
        chk("mem_enable",    {31'h0, mem_enable},  {31'h0, e_mem_en});
        chk("mem_wr",        {31'h0, mem_wr},      {31'h0, e_mem_wr});
        chk("mem_addr",      {16'h0, mem_addr},    {16'h0, e_mem_addr});
        chk("mem_data_in",   mem_data_in,          e_mem_din);
        chk("err",           {31'h0, err},         {31'h0, e_err});
        chk("ready_excl",    {31'h0, imem_ready & dmem_ready}, 32'h0);
    end

    // Waits for the chosen ready pulse; returns positioned 1 time unit after
    // the edge that raised it.
    task automatic wait_ready(input bit is_fetch, input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (is_fetch ? imem_ready : dmem_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk(is_fetch ? "imem_ready_wait" : "dmem_ready_wait", {31'h0, ok}, 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    initial begin : stim
        int got_grants;
        int pulses;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_enable", {31'h0, mem_enable}, 32'h0);
        chk("rst_err",        {31'h0, err},        32'h0);
        chk("rst_imem_ready", {31'h0, imem_ready}, 32'h0);
        rst = 1'b1;

        // Fetch only, zero-wait memory, address 0x0004
        @(posedge clk); #1;
        imem_req = 1'b1; imem_addr = 16'h0004;
        @(posedge clk); #1;
        chk("f_mem_enable", {31'h0, mem_enable}, 32'h1);
        chk("f_mem_addr",   {16'h0, mem_addr},   32'h0004);
        @(posedge clk); #1;
        chk("f_imem_ready", {31'h0, imem_ready}, 32'h1);
        chk("f_imem_data",  imem_data_out,       32'hC0DE0004);
        chk("f_dmem_ready", {31'h0, dmem_ready}, 32'h0);
        @(posedge clk); #1;
        imem_req = 1'b0;
        chk("f_ready_once", {31'h0, imem_ready}, 32'h0);

        // Store then load at 0x0010 through a one-wait memory
        wait_cfg = 1;
        dmem_req = 1'b1; dmem_wr = 1'b1; dmem_addr = 16'h0010; dmem_data_in = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk("st_mem_wr",  {31'h0, mem_wr}, 32'h1);
        chk("st_mem_din", mem_data_in,      32'hDEADBEEF);
        wait_ready(1'b0, 20);
        chk("st_dout_kept", dmem_data_out, 32'h0);
        @(posedge clk); #1;
        dmem_wr = 1'b0; dmem_data_in = 32'h0;
        @(posedge clk); #1;
        chk("ld_mem_wr", {31'h0, mem_wr}, 32'h0);
        chk("ld_mem_en", {31'h0, mem_enable}, 32'h1);
        wait_ready(1'b0, 20);
        chk("ld_data", dmem_data_out, 32'hDEADBEEF);
        @(posedge clk); #1;
        dmem_req = 1'b0;

        // Both requesters held continuously: D,D,D,D,I repeating
        wait_cfg = 0;
        imem_req = 1'b1; imem_addr = 16'h0020;
        dmem_req = 1'b1; dmem_wr = 1'b0; dmem_addr = 16'h0030;
        pulses = 0;
        for (int k = 0; k < 80 && pulses < 10; k++) begin
            @(posedge clk); #1;
            if (imem_ready || dmem_ready) begin
                chk("grant_order", {31'h0, imem_ready}, (pulses % 5 == 4) ? 32'h1 : 32'h0);
                if (pulses == 4) chk("grant_idata", imem_data_out, 32'hC0DE0020);
                if (pulses == 0) chk("grant_ddata", dmem_data_out, 32'hC0DE0030);
                pulses++;
            end
        end
        chk("grant_count", pulses, 10);
        @(posedge clk); #1;
        imem_req = 1'b0; dmem_req = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a three-wait data grant, fetch pending
        wait_cfg = 3;
        dmem_req = 1'b1; dmem_wr = 1'b0; dmem_addr = 16'h0040;
        imem_req = 1'b1; imem_addr = 16'h0008;
        @(posedge clk); #1;
        chk("rd_in_dgnt", {16'h0, mem_addr}, 32'h0040);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("rst_async_en",   {31'h0, mem_enable}, 32'h0);
        chk("rst_async_addr", {16'h0, mem_addr},   32'h0);
        chk("rst_async_dout", dmem_data_out,       32'h0);
        dmem_req = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_no_dready", {31'h0, dmem_ready}, 32'h0);
        end
        rst = 1'b1;
        wait_ready(1'b1, 20);
        chk("rst_fetch_data", imem_data_out, 32'hC0DE0008);
        @(posedge clk); #1;
        imem_req = 1'b0;
        @(posedge clk); #1;

        // Memory never ready: timeout after 255 grant cycles
        hold_low = 1'b1;
        imem_req = 1'b1; imem_addr = 16'h0050;
        got_grants = 0;
        pulses = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (mem_enable) got_grants++;
            if (imem_ready) begin
                pulses = 1;
                break;
            end
        end
        chk("to_pulse",  pulses,              1);
        chk("to_cycles", got_grants,          255);
        chk("to_err",    {31'h0, err},        32'h1);
        chk("to_data",   imem_data_out,       32'h0);
        @(posedge clk); #1;
        imem_req = 1'b0;
        hold_low = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("to_err_sticky", {31'h0, err}, 32'h1);
        rst = 1'b0;
        #1;
        chk("to_err_clear", {31'h0, err}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_DSTREAK, default 4, giving the number of consecutive data grants allowed while a fetch waits.
REQ-002 SHALL have parameter TIMEOUT, default 255, giving the number of grant-state cycles without mem_ready before an error.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports imem_req (in, 1) and imem_addr (in, 16): the instruction-fetch request and its address.
REQ-006 SHALL have ports imem_data_out (out, 32) and imem_ready (out, 1): the fetch data and its one-cycle completion pulse.
REQ-007 SHALL have ports dmem_req (in, 1), dmem_wr (in, 1), dmem_addr (in, 16) and dmem_data_in (in, 32): the data request, write flag, address and store data.
REQ-008 SHALL have ports dmem_data_out (out, 32) and dmem_ready (out, 1): the load data and its one-cycle completion pulse.
REQ-009 SHALL have ports mem_enable (out, 1), mem_wr (out, 1), mem_addr (out, 16) and mem_data_in (out, 32): the request side of the shared stalling memory.
REQ-010 SHALL have ports mem_data_out (in, 32) and mem_ready (in, 1): the read data and completion indication from the shared memory.
REQ-011 SHALL have port err, output, 1 bit: sticky memory-timeout flag.

Function
REQ-012 SHALL implement FSM states IDLE, IGNT, DGNT and RESP, with all outputs registered.
REQ-013 SHALL require each requester to hold its req and operands stable until its ready pulse, then drop or change them on the following cycle.
REQ-014 In IDLE, SHALL go to DGNT when dmem_req=1 and either imem_req=0 or streak<MAX_DSTREAK.
REQ-015 In IDLE, SHALL otherwise go to IGNT when imem_req=1; with no request it SHALL remain in IDLE.
REQ-016 On the IDLE->grant edge, SHALL latch the winner's addr, wr and data onto mem_addr, mem_wr and mem_data_in, and set mem_enable=1; a fetch SHALL force mem_wr=0.
REQ-017 The streak counter SHALL increment on a DGNT grant made while imem_req=1, clear on an IGNT grant or on a DGNT grant made while imem_req=0, and saturate at MAX_DSTREAK.
REQ-018 In a grant state with mem_ready=1, SHALL register mem_data_out to the winner's data_out, pulse the winner's ready for exactly one cycle (the RESP cycle), and drop mem_enable/mem_wr.
REQ-019 On a data write, SHALL leave dmem_data_out at its previous value; dmem_ready SHALL still pulse.
REQ-020 RESP SHALL return to IDLE unconditionally.
REQ-021 Minimum latency SHALL be req sampled at edge N, mem_enable high in cycle N+1, ready pulse in cycle N+2, one transaction per 3 cycles.
REQ-022 A wait counter SHALL clear on grant and increment each grant-state cycle with mem_ready=0.
REQ-023 When the wait counter reaches TIMEOUT, SHALL set err=1, go to RESP with the winner's data_out=32'h0 and ready pulsed, and drop mem_enable.
REQ-024 err SHALL remain set until reset.
REQ-025 SHALL never assert imem_ready and dmem_ready in the same cycle, and SHALL assert mem_enable only in IGNT or DGNT.

Reset
REQ-026 While rst=0, SHALL immediately (without a clock) enter IDLE and zero every output, the streak counter and the wait counter, including mid-transaction.
REQ-027 After rst returns high, SHALL start arbitration on the first rising edge.

Verification
REQ-028 Fetch only, imem_addr=16'h0004, zero-wait memory -> mem_enable at N+1 with mem_addr=16'h0004, imem_ready pulse at N+2 carrying the memory word, dmem_ready=0 throughout.
REQ-029 imem_req and dmem_req held continuously, MAX_DSTREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I..., never two ready pulses in one cycle.
REQ-030 Store dmem_wr=1, addr=16'h0010, data=32'hDEADBEEF, followed by a load from 16'h0010 -> mem_wr=1 only during the store grant, and the load returns 32'hDEADBEEF.
REQ-031 mem_ready held low with TIMEOUT=255 -> after 255 grant cycles err=1, ready pulse with data 32'h0, and err stays 1 until rst=0.
REQ-032 rst pulled low while in DGNT with a 3-wait memory -> outputs are 0 asynchronously, no ready pulse occurs, and after release a pending fetch completes normally.
